// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants for the fetch/decode instruction buffer
// and the instruction predecoder.
//   ZERO_WORD   - bubble value driven on pc/inst when the queue is empty
//   RST_ENABLE  - active level of the synchronous reset
//   OPC_*       - opcode[6:2] values of RV32I control-flow instructions
//   is_ctrl_opcode() - true for branch, jalr and jal opcodes
package if_id_queue_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  function automatic logic is_ctrl_opcode(input logic [4:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JALR) || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/if_id_queue_inst_predecode.sv
// inst_predecode: purely combinational control-flow detector.
//   inst    (in)  instruction word
//   is_ctrl (out) 1 when opcode[6:2] is branch, jalr or jal
// Shared with the fetch stage for branch prediction, so it only looks at
// the opcode field and carries no state.
module inst_predecode
  import if_id_queue_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic              is_ctrl
);

  // Only the opcode field matters; the remaining bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{inst[INST_W-1:7], inst[1:0]};

  assign is_ctrl = is_ctrl_opcode(inst[6:2]);

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry ring buffer of (pc, inst) pairs between fetch
// and decode, with valid/ready on both sides and a one-cycle flush.
//   clk, rst      clock, synchronous active-high reset
//   rdy           global enable; when low all state holds
//   in_valid/in_ready, in_pc, in_inst      fetch side (in_ready = !full)
//   out_valid/out_ready, out_pc, out_inst  decode side, zero bubble when empty
//   out_is_ctrl   head instruction is branch/jalr/jal (0 when empty)
//   flush         discard all entries (decode redirect)
//   count         current occupancy
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic                       out_is_ctrl,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_ctrl;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // in_ready looks at occupancy only, so there is no out_ready -> in_ready path.
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = rdy & in_valid & in_ready & !flush;
  assign pop  = rdy & out_valid & out_ready & !flush;

  // Control: pointers and occupancy. Pointers are PTR_W bits and DEPTH is a
  // power of two, so increments wrap without an explicit compare.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage: not reset; stale slots are never visible because out_valid
  // and the bubble gating depend on count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= in_pc;
      inst_mem[tail] <= in_inst;
    end
  end

  // Output: combinational read of the head slot, forced to zero when empty.
  assign out_pc   = empty ? ADDR_W'(ZERO_WORD) : pc_mem[head];
  assign out_inst = empty ? INST_W'(ZERO_WORD) : inst_mem[head];

  inst_predecode #(
    .INST_W (INST_W)
  ) u_predecode (
    .inst    (inst_mem[head]),
    .is_ctrl (head_ctrl)
  );

  assign out_is_ctrl = out_valid & head_ctrl;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed stimulus for if_id_queue, checked
// every cycle against a queue-based reference model of the buffer.
module tb_if_id_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_is_ctrl;
  logic              flush;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t mdl_q[$];

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_is_ctrl (out_is_ctrl),
    .flush       (flush),
    .count       (count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_is_ctrl(input logic [INST_W-1:0] inst);
    logic [4:0] opc;
    opc = inst[6:2];
    return (opc == 5'b11000) || (opc == 5'b11001) || (opc == 5'b11011);
  endfunction

  // Compare all outputs against the model, then advance model and clock.
  task automatic cycle(input logic r, input logic rd, input logic iv,
                       input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] ins,
                       input logic ordy, input logic fl);
    logic do_push;
    logic do_pop;
    ent_t e;
    rst = r; rdy = rd; in_valid = iv; in_pc = pc; in_inst = ins;
    out_ready = ordy; flush = fl;
    #1;
    check_val("count", 64'(count), 64'(mdl_q.size()));
    check_val("in_ready", 64'(in_ready), 64'(mdl_q.size() < DEPTH));
    check_val("out_valid", 64'(out_valid), 64'(mdl_q.size() > 0));
    if (mdl_q.size() > 0) begin
      check_val("out_pc", 64'(out_pc), 64'(mdl_q[0].pc));
      check_val("out_inst", 64'(out_inst), 64'(mdl_q[0].inst));
      check_val("out_is_ctrl", 64'(out_is_ctrl), 64'(ref_is_ctrl(mdl_q[0].inst)));
    end else begin
      check_val("bubble_pc", 64'(out_pc), 64'h0);
      check_val("bubble_inst", 64'(out_inst), 64'h0);
      check_val("bubble_ctrl", 64'(out_is_ctrl), 64'h0);
    end
    if (r) begin
      mdl_q.delete();
    end else if (rd) begin
      if (fl) begin
        mdl_q.delete();
      end else begin
        do_push = iv && (mdl_q.size() < DEPTH);
        do_pop  = ordy && (mdl_q.size() > 0);
        if (do_pop) void'(mdl_q.pop_front());
        if (do_push) begin
          e.pc = pc;
          e.inst = ins;
          mdl_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [INST_W-1:0] rand_inst();
    logic [INST_W-1:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'b1100011;
      1: w[6:0] = 7'b1100111;
      2: w[6:0] = 7'b1101111;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [ADDR_W-1:0] pc_seq;
    rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Reset held two cycles with in_valid asserted.
    cycle(1, 1, 1, 32'h100, 32'h13, 0, 0);
    cycle(1, 1, 1, 32'h104, 32'h13, 0, 0);
    check_val("rst_count", 64'(count), 64'h0);
    check_val("rst_out_valid", 64'(out_valid), 64'h0);
    check_val("rst_out_inst", 64'(out_inst), 64'h0);
    check_val("rst_in_ready", 64'(in_ready), 64'h1);

    // Fill to full, extra push dropped, then drain in order.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 32'(i * 4), 32'h0000_0013, 0, 0);
    check_val("full_count", 64'(count), 64'h4);
    check_val("full_in_ready", 64'(in_ready), 64'h0);
    cycle(0, 1, 1, 32'h10, 32'h0000_0013, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("drain_pc", 64'(out_pc), 64'(i * 4));
      cycle(0, 1, 0, '0, '0, 1, 0);
    end
    check_val("drain_bubble", 64'(out_valid), 64'h0);

    // Concurrent push/pop at count=2; pointers wrap more than twice.
    cycle(0, 1, 1, 32'h200, 32'h13, 0, 0);
    cycle(0, 1, 1, 32'h204, 32'h13, 0, 0);
    pc_seq = 32'h208;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, pc_seq, rand_inst(), 1, 0);
      pc_seq += 4;
    end
    check_val("conc_count", 64'(count), 64'h2);
    check_val("conc_head_pc", 64'(out_pc), 64'h228);

    // Count=3, then flush together with push of 0x20 and pop.
    cycle(0, 1, 1, 32'h300, 32'h13, 0, 0);
    check_val("pre_flush_count", 64'(count), 64'h3);
    cycle(0, 1, 1, 32'h20, 32'h13, 1, 1);
    check_val("flush_count", 64'(count), 64'h0);
    check_val("flush_out_valid", 64'(out_valid), 64'h0);
    cycle(0, 1, 1, 32'h400, 32'h6F, 1, 0);
    check_val("post_flush_pc", 64'(out_pc), 64'h400);
    cycle(0, 1, 0, '0, '0, 1, 0);

    // rdy low for 3 cycles at count=2.
    cycle(0, 1, 1, 32'h500, 32'h13, 0, 0);
    cycle(0, 1, 1, 32'h504, 32'h13, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h5F0, 32'h13, 1, 0);
    check_val("hold_count", 64'(count), 64'h2);
    check_val("hold_head_pc", 64'(out_pc), 64'h500);
    cycle(0, 1, 0, '0, '0, 1, 0);
    check_val("resume_pc", 64'(out_pc), 64'h504);
    cycle(0, 1, 0, '0, '0, 1, 0);

    // Predecode: jal, addi, bubble.
    cycle(0, 1, 1, 32'h600, 32'h0000_006F, 0, 0);
    check_val("pd_jal", 64'(out_is_ctrl), 64'h1);
    cycle(0, 1, 1, 32'h604, 32'h0000_0013, 1, 0);
    check_val("pd_addi", 64'(out_is_ctrl), 64'h0);
    cycle(0, 1, 0, '0, '0, 1, 0);
    check_val("pd_bubble", 64'(out_is_ctrl), 64'h0);

    // Random traffic with occasional reset, flush and stall.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) != 0),
            $urandom, rand_inst(),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
